// File: rtl/dmem_ctrl.sv
// Data-memory responder for the RV32I pipeline: turns an EX-MA load/store into
// a request/grant/response bus transaction and returns aligned, extended load data.
module dmem_ctrl #(
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Count of the final allowed BUS/RSP cycle; unused when the timeout is disabled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]        state_q;
  logic              lat_we_q;
  logic [1:0]        lat_off_q;
  logic [1:0]        lat_size_q;
  logic              lat_sign_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic [CNT_W-1:0]  tmo_cnt_q;

  logic        req_illegal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        timeout_hit;

  assign req_illegal = (size_i == 2'b11)
                     | ((size_i == SZ_HALF) & addr_i[0])
                     | ((size_i == SZ_WORD) & (addr_i[1:0] != 2'b00));

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wdata_i;
    if (we_i) begin
      case (size_i)
        SZ_BYTE: begin
          be_nxt    = 4'b0001 << addr_i[1:0];
          wdata_nxt = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          be_nxt    = 4'b0011 << addr_i[1:0];
          wdata_nxt = {2{wdata_i[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = wdata_i;
        end
      endcase
    end
  end

  // Lane select uses the offset latched at request time, not the live address.
  assign rd_shift = mem_rdata_i >> {lat_off_q, 3'b000};

  always_comb begin
    rd_ext = mem_rdata_i;
    case (lat_size_q)
      SZ_BYTE: rd_ext = {{24{lat_sign_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rd_ext = {{16{lat_sign_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = mem_rdata_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == CNT_LAST);

  // NOTE: state and all bus outputs are flops updated with non-blocking assignments;
  // reset clears them asynchronously so an in-flight access is simply dropped.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      lat_we_q    <= 1'b0;
      lat_off_q   <= 2'b00;
      lat_size_q  <= 2'b00;
      lat_sign_q  <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            lat_we_q   <= we_i;
            lat_off_q  <= addr_i[1:0];
            lat_size_q <= size_i;
            lat_sign_q <= sign_i;
            rdata_q    <= '0;
            if (req_illegal) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q       <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_i;
              mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_nxt;
              mem_wdata_q <= we_i ? wdata_nxt : 32'h0;
              tmo_cnt_q   <= '0;
              state_q     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          if (mem_gnt_i && mem_rvalid_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!lat_we_q) rdata_q <= rd_ext;
            state_q   <= ST_DONE;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= ST_DONE;
          end else if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_RSP;
          end
        end
        ST_RSP: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // A response in the last allowed cycle still wins over the timeout.
          if (mem_rvalid_i) begin
            if (!lat_we_q) rdata_q <= rd_ext;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o     = ((state_q == ST_IDLE) & req_i) | (state_q == ST_BUS) | (state_q == ST_RSP);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q & done_o;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
